// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to an x(n) = x(n-TAP) ^ x(n-N) stream, declares lock,
// then counts bit errors and checked bits with saturating counters.
module prbs_checker #(
  parameter int unsigned N        = 3,
  parameter int unsigned TAP      = 1,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ECW      = 16,
  parameter int unsigned BCW      = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  input  logic           din_valid,
  input  logic           clear,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_count,
  output logic [BCW-1:0] bit_count
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {StFill, StHunt, StLocked} state_e;

  state_e         state_q, state_d;
  logic [N:1]     h_q, h_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [GW-1:0]  good_q, good_d;
  logic [BW-1:0]  bad_q, bad_d;
  logic           err_q, err_d;
  logic [ECW-1:0] ec_q, ec_d;
  logic [BCW-1:0] bc_q, bc_d;

  logic pred, match, h_zero;

  assign pred   = h_q[TAP] ^ h_q[N];
  assign match  = (din == pred);
  assign h_zero = (h_q == '0);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    ec_d    = ec_q;
    bc_d    = bc_q;
    if (din_valid) begin
      unique case (state_q)
        StFill: begin
          h_d = {h_q[N-1:1], din};
          if (fill_q == FW'(N - 1)) begin
            state_d = StHunt;
            fill_d  = '0;
            good_d  = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        StHunt: begin
          h_d = {h_q[N-1:1], din};
          // An all-zero history predicts 0 forever; never count that as progress.
          if (match && !h_zero) begin
            if (good_q == GW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        StLocked: begin
          // Free-running reference: a flipped input bit must not corrupt later predictions.
          h_d = {h_q[N-1:1], pred};
          if (~&bc_q) bc_d = bc_q + BCW'(1);
          if (!match) begin
            err_d = 1'b1;
            if (~&ec_q) ec_d = ec_q + ECW'(1);
            if (bad_q == BW'(LOSS_CNT - 1)) begin
              state_d = StHunt;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = StFill;
      endcase
    end
    if (clear) begin
      ec_d = '0;
      bc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      h_q     <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      ec_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
      bc_q    <= bc_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err       = err_q;
  assign err_count = ec_q;
  assign bit_count = bc_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table vectors, hand-written corner sequences and a randomized run
// compared against a queue-based reference model; a narrow-counter instance covers saturation.
module tb_prbs_checker;

  localparam int N        = 3;
  localparam int TAP      = 1;
  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam int ECW_B    = 4;
  localparam int BCW_B    = 6;
  localparam int MFILL    = 0;
  localparam int MHUNT    = 1;
  localparam int MLOCK    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clear = 1'b0;

  logic              locked_a, err_a;
  logic [15:0]       ec_a;
  logic [31:0]       bc_a;
  logic              locked_b, err_b;
  logic [ECW_B-1:0]  ec_b;
  logic [BCW_B-1:0]  bc_b;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked_a), .err(err_a), .err_count(ec_a), .bit_count(bc_a)
  );

  prbs_checker #(.ECW(ECW_B), .BCW(BCW_B)) dut_small (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked_b), .err(err_b), .err_count(ec_b), .bit_count(bc_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Generator output for seed 111, period 7: 1,1,1,0,1,0,0
  logic [6:0] pat = 7'b1110100;
  int gidx = 1;

  function automatic bit gen(input int i);
    return pat[6 - ((i - 1) % 7)];
  endfunction

  // Reference model
  bit     hist[$];
  int     m_mode, m_fill, m_good, m_bad;
  longint m_errs, m_bits;
  bit     m_err;

  function automatic longint sat(input longint x, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    hist = {};
    repeat (N) hist.push_back(1'b0);
    m_mode = MFILL; m_fill = 0; m_good = 0; m_bad = 0;
    m_errs = 0; m_bits = 0; m_err = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit c);
    bit p, nz;
    m_err = 0;
    if (v) begin
      p  = hist[TAP-1] ^ hist[N-1];
      nz = 0;
      foreach (hist[k]) if (hist[k]) nz = 1;
      if (m_mode == MFILL) begin
        hist.push_front(d); void'(hist.pop_back());
        m_fill++;
        if (m_fill == N) begin m_mode = MHUNT; m_good = 0; end
      end else if (m_mode == MHUNT) begin
        if (d == p && nz) m_good++; else m_good = 0;
        hist.push_front(d); void'(hist.pop_back());
        if (m_good == LOCK_CNT) begin m_mode = MLOCK; m_bad = 0; end
      end else begin
        m_bits++;
        if (d != p) begin m_err = 1; m_errs++; m_bad++; end
        else m_bad = 0;
        hist.push_front(p); void'(hist.pop_back());
        if (m_bad == LOSS_CNT) begin m_mode = MHUNT; m_good = 0; end
      end
    end
    if (c) begin m_errs = 0; m_bits = 0; end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " locked"}, longint'(locked_a), longint'(m_mode == MLOCK));
    check({tag, " err"}, longint'(err_a), longint'(m_err));
    check({tag, " err_count"}, longint'(ec_a), sat(m_errs, 16));
    check({tag, " bit_count"}, longint'(bc_a), sat(m_bits, 32));
    check({tag, " small err_count"}, longint'(ec_b), sat(m_errs, ECW_B));
    check({tag, " small bit_count"}, longint'(bc_b), sat(m_bits, BCW_B));
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clear = c;
    @(posedge clk); #1;
    model_step(d, v, c);
  endtask

  task automatic send_good(input string tag);
    step(gen(gidx), 1'b1, 1'b0); gidx++;
    check_model(tag);
  endtask

  task automatic send_bad(input string tag);
    step(~gen(gidx), 1'b1, 1'b0); gidx++;
    check_model(tag);
  endtask

  task automatic do_reset();
    din = 0; din_valid = 0; clear = 0; rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    model_reset();
    gidx = 1;
    check_model("reset");
  endtask

  typedef struct {
    bit d; bit v; bit c;
    bit exp_locked; bit exp_err; int exp_ec; int exp_bc;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_err;
    int burst;
    model_reset();

    // Lock from reset, counting, a gap, a lone error, clear colliding with an error.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{1, 1, 0, 1, 1, 1, 2};
    tbl[14] = '{0, 1, 0, 1, 0, 1, 3};
    tbl[15] = '{0, 1, 1, 1, 1, 0, 0};
    tbl[16] = '{1, 1, 0, 1, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].d, tbl[i].v, tbl[i].c);
      check($sformatf("tbl[%0d] locked", i), longint'(locked_a), longint'(tbl[i].exp_locked));
      check($sformatf("tbl[%0d] err", i), longint'(err_a), longint'(tbl[i].exp_err));
      check($sformatf("tbl[%0d] err_count", i), longint'(ec_a), longint'(tbl[i].exp_ec));
      check($sformatf("tbl[%0d] bit_count", i), longint'(bc_a), longint'(tbl[i].exp_bc));
    end

    // Clean stream: lock after bit 11, then 70 checked bits with no errors.
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      send_good("lock");
      check($sformatf("lock bit %0d locked", i), longint'(locked_a), longint'(i == 11));
    end
    saw_err = 0;
    for (int i = 0; i < 70; i++) begin
      send_good("clean");
      if (err_a) saw_err = 1;
    end
    check("clean bit_count", longint'(bc_a), 70);
    check("clean err_count", longint'(ec_a), 0);
    check("clean err seen", longint'(saw_err), 0);

    // Single inverted bit.
    send_bad("single");
    check("single err", longint'(err_a), 1);
    check("single err_count", longint'(ec_a), 1);
    check("single locked", longint'(locked_a), 1);
    for (int i = 0; i < 5; i++) send_good("single after");
    check("single after err_count", longint'(ec_a), 1);

    // Four consecutive errors drop lock; relock after 8 correct bits.
    step(1'b0, 1'b0, 1'b1); check_model("clear");
    for (int i = 1; i <= LOSS_CNT; i++) begin
      send_bad("burst");
      check($sformatf("burst %0d err", i), longint'(err_a), 1);
      check($sformatf("burst %0d locked", i), longint'(locked_a), longint'(i < LOSS_CNT));
    end
    check("burst err_count", longint'(ec_a), 4);
    for (int i = 1; i <= LOCK_CNT; i++) begin
      send_good("relock");
      check($sformatf("relock %0d locked", i), longint'(locked_a), longint'(i == LOCK_CNT));
    end

    // Valid toggling every cycle: only valid bits are counted.
    step(1'b0, 1'b0, 1'b1); check_model("clear");
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_good("toggle");
      else begin step(1'b1, 1'b0, 1'b0); check_model("toggle gap"); end
    end
    check("toggle bit_count", longint'(bc_a), 20);
    check("toggle err_count", longint'(ec_a), 0);
    step(~gen(gidx), 1'b1, 1'b1); gidx++; check_model("clear+err");
    check("clear+err err", longint'(err_a), 1);
    check("clear+err err_count", longint'(ec_a), 0);
    send_good("after clear+err");

    // Stuck-at-0 line must never lock.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0); check_model("stuck0");
    end
    check("stuck0 locked", longint'(locked_a), 0);
    check("stuck0 bit_count", longint'(bc_a), 0);

    // Saturation: 3 errors + 1 good keeps lock while piling up errors.
    do_reset();
    for (int i = 0; i < 11; i++) send_good("sat lock");
    for (int g = 0; g < 20; g++) begin
      send_bad("sat"); send_bad("sat"); send_bad("sat"); send_good("sat");
    end
    check("sat small err_count", longint'(ec_b), 15);
    check("sat small bit_count", longint'(bc_b), 63);
    check("sat err_count", longint'(ec_a), 60);
    check("sat locked", longint'(locked_a), 1);

    // Asynchronous reset between clock edges.
    #2 rst = 1;
    #1;
    check("async locked", longint'(locked_a), 0);
    check("async err_count", longint'(ec_a), 0);
    check("async bit_count", longint'(bc_a), 0);
    check("async small err_count", longint'(ec_b), 0);
    din_valid = 0;
    @(negedge clk); rst = 0;
    model_reset();
    for (int i = 1; i <= 11; i++) begin
      send_good("post-reset");
      check($sformatf("post-reset %0d locked", i), longint'(locked_a), longint'(i == 11));
    end

    // Randomized traffic against the model.
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      bit v, c, inv;
      v = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 39) == 0);
      inv = 0;
      if (burst > 0) begin inv = 1; burst--; end
      else if ($urandom_range(0, 49) == 0) burst = $urandom_range(2, 6);
      else if ($urandom_range(0, 11) == 0) inv = 1;
      if ($urandom_range(0, 149) == 0) gidx += $urandom_range(1, 6);
      step(gen(gidx) ^ inv, v, c);
      if (v) gidx++;
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that sits directly downstream of the 3-bit PRBS generator. It consumes the generator's serial bit stream (feedback stage output, x(n) = x(n-1) ^ x(n-3)), self-synchronises to it, and declares lock. While locked, it counts bit errors and checked bits for bit-error-rate measurement. It drops lock on sustained errors.

## Interface
Parameters:
- N, 3: LFSR length; history depth.
- TAP, 1: second feedback tap; predicted bit = h[TAP] ^ h[N].
- LOCK_CNT, 8: consecutive correct predictions needed to lock.
- LOSS_CNT, 4: consecutive errors while locked that force relock.
- ECW, 16: err_count width.
- BCW, 32: bit_count width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- din  in  1  received serial PRBS bit.
- din_valid  in  1  qualifies din; the bit is sampled on a rising edge with din_valid=1.
- clear  in  1  synchronous clear of err_count and bit_count; state and lock are unaffected.
- locked  out  1  checker is in the LOCKED state.
- err  out  1  one-cycle pulse per detected bit error.
- err_count  out  ECW  saturating count of errors while locked.
- bit_count  out  BCW  saturating count of bits checked while locked.

## Operation
- History register h[1..N]: h[1] is the most recent bit. A shift moves h[k] to h[k+1] and the new bit to h[1].
- pred = h[TAP] ^ h[N].
- Only edges with din_valid=1 advance anything. With din_valid=0, all state and outputs hold, except err, which returns to 0.

FSM:
- FILL (reset state):
  - Each valid bit shifts din into h.
  - After N valid bits, go to HUNT with good=0.
- HUNT:
  - Each valid bit compares din to pred, then shifts din into h.
  - Match with pre-shift h not all-zero: good+1.
  - Mismatch, or pre-shift h all-zero: good=0. This prevents a stuck-at-0 line from locking.
  - When good reaches LOCK_CNT, go to LOCKED with bad=0.
  - No err pulses and no counting in HUNT.
- LOCKED:
  - Each valid bit compares din to pred, then shifts pred, not din, into h. The reference free-runs, so a single flipped bit gives exactly one error.
  - Every valid bit: bit_count+1.
  - Mismatch: err=1, err_count+1, bad+1.
  - Match: bad=0.
  - When bad reaches LOSS_CNT, go to HUNT with good=0. From that edge on, h is reloaded with received bits. That final error is still counted.
- Counters saturate at all-ones and never wrap.
- clear=1 on an edge sets err_count=0 and bit_count=0. Clear has priority over a simultaneous increment, so that bit is not counted. The err pulse still fires.
- err_count and bit_count hold their values across loss of lock and relock.

## Timing
- Reset values:
  - state=FILL, h=0, good=0, bad=0.
  - locked=0, err=0, err_count=0, bit_count=0.
- All outputs are registered. Each updates on the edge that samples the bit and is visible in the following cycle.
- Lock latency from reset, counted with an error-free stream: locked rises after the (N+LOCK_CNT)-th valid bit (11 with defaults).
- err latency: err is high for exactly one cycle after the sampling edge of the bad bit. Back-to-back errors keep err high continuously.
- Unlock: locked falls on the edge sampling the LOSS_CNT-th consecutive error.
- Reset asserted mid-stream: immediate return to FILL with all counters zeroed. After release, lock needs another N+LOCK_CNT valid bits.
- Gaps in din_valid do not affect lock; only valid bits are counted.

## Test plan
- Reset, then continuous valid stream from the seed-111 generator output 1,1,1,0,1,0,0,1,1,1,0,1,0,0,… → locked=1 after the 11th bit. After 70 further bits: bit_count=70, err_count=0, err never asserted.
- Locked, then invert one bit → single one-cycle err pulse, err_count=1, locked stays 1. The following bits give no err.
- Locked, then invert 4 consecutive bits → err high for 4 cycles, err_count=4, locked falls with the 4th. Then a clean stream gives relock after 8 correct bits, with no FILL pass.
- din held at 0 with din_valid=1 for 100 cycles after reset → locked stays 0, err stays 0, counters stay 0.
- Locked stream with din_valid toggling 1/0 each cycle for 40 cycles → bit_count=20, no errors. clear pulsed together with an injected error → err_count=0, err pulses once.
- Force err_count to its saturation value 0xFFFF via continued errors → err_count holds at 0xFFFF. Assert rst mid-stream → all outputs 0 immediately, without waiting for a clock edge.
